// File: rtl/jk_pkg.sv
// Shared op encodings and FSM state type for the JK bank arbiter.
package jk_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StApply
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit; asynchronous active-high reset clears it to 0.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sequencing two requesters' op/mask/count commands onto a JK bank.
// Optional done/done_id pulse outputs are enabled by defining JK_DONE_PULSE_EN.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  input  logic [CNT_W-1:0] req0_cnt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  input  logic [CNT_W-1:0] req1_cnt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             grant_id
`ifdef JK_DONE_PULSE_EN
  ,
  output logic             done,
  output logic             done_id
`endif
);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] rem_q;
  logic             last_q;

  logic             sel;
  logic             idle_ok;
  logic             fire;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [CNT_W-1:0] sel_cnt;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  // Under contention the requester not granted last time wins.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_q;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
    sel_op   = sel ? req1_op   : req0_op;
    sel_mask = sel ? req1_mask : req0_mask;
    sel_cnt  = sel ? req1_cnt  : req0_cnt;
  end

  // Ready is held low while reset is asserted even though state already reads idle.
  assign idle_ok    = !rst && (state_q == StIdle);
  assign req0_ready = idle_ok && req0_valid && !sel;
  assign req1_ready = idle_ok && req1_valid && sel;
  assign fire       = req0_ready || req1_ready;

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (state_q == StApply) begin
      j_vec = {WIDTH{op_q[1]}} & mask_q;
      k_vec = {WIDTH{op_q[0]}} & mask_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OP_HOLD;
      mask_q   <= '0;
      rem_q    <= '0;
      last_q   <= 1'b1;
      busy     <= 1'b0;
      grant_id <= 1'b0;
`ifdef JK_DONE_PULSE_EN
      done     <= 1'b0;
      done_id  <= 1'b0;
`endif
    end else begin
`ifdef JK_DONE_PULSE_EN
      done <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (fire) begin
            op_q     <= sel_op;
            mask_q   <= sel_mask;
            rem_q    <= (sel_cnt == '0) ? CNT_W'(1) : sel_cnt;
            grant_id <= sel;
            last_q   <= sel;
            busy     <= 1'b1;
            state_q  <= StApply;
          end
        end
        StApply: begin
          if (rem_q == CNT_W'(1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
`ifdef JK_DONE_PULSE_EN
            done    <= 1'b1;
            done_id <= grant_id;
`endif
          end else begin
            rem_q <= rem_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[i]),
      .k   (k_vec[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter; done/done_id are checked when JK_DONE_PULSE_EN is defined.
module tb_jk_bank_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [1:0]       req0_op = 2'b00;
  logic [WIDTH-1:0] req0_mask = '0;
  logic [CNT_W-1:0] req0_cnt = '0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [1:0]       req1_op = 2'b00;
  logic [WIDTH-1:0] req1_mask = '0;
  logic [CNT_W-1:0] req1_cnt = '0;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             grant_id;
`ifdef JK_DONE_PULSE_EN
  logic             done;
  logic             done_id;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_mask  (req0_mask),
    .req0_cnt   (req0_cnt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_mask  (req1_mask),
    .req1_cnt   (req1_cnt),
    .q          (q),
    .busy       (busy),
    .grant_id   (grant_id)
`ifdef JK_DONE_PULSE_EN
    ,
    .done       (done),
    .done_id    (done_id)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted mid-cycle, with both requesters valid to show ready is gated.
    #2 rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_ready0", 32'(req0_ready), 32'h0);
    chk("rst_ready1", 32'(req1_ready), 32'h0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_ready0_novalid", 32'(req0_ready), 32'h0);
    chk("idle_ready1_novalid", 32'(req1_ready), 32'h0);
    req1_valid = 1'b1;
    #1;
    chk("idle_ready1_valid", 32'(req1_ready), 32'h1);
    chk("idle_ready0_other", 32'(req0_ready), 32'h0);
    req1_valid = 1'b0;

    // Single SET command from requester 0.
    tick();
    req0_valid = 1'b1; req0_op = 2'b10; req0_mask = 8'hF0; req0_cnt = 4'd1;
    #1;
    chk("set_ready0", 32'(req0_ready), 32'h1);
    tick();
    req0_valid = 1'b0;
    chk("set_busy_accept", 32'(busy), 32'h1);
    chk("set_grant", 32'(grant_id), 32'h0);
    chk("set_q_accept", 32'(q), 32'h00);
    chk("set_ready_apply", 32'(req0_ready), 32'h0);
    tick();
    chk("set_q", 32'(q), 32'hF0);
    chk("set_busy_end", 32'(busy), 32'h0);
`ifdef JK_DONE_PULSE_EN
    chk("set_done", 32'(done), 32'h1);
    chk("set_done_id", 32'(done_id), 32'h0);
`endif

    // Requester 1 toggles bit 0 three times.
    req1_valid = 1'b1; req1_op = 2'b11; req1_mask = 8'h01; req1_cnt = 4'd3;
    tick();
    req1_valid = 1'b0;
    chk("tog_grant", 32'(grant_id), 32'h1);
    chk("tog_busy0", 32'(busy), 32'h1);
`ifdef JK_DONE_PULSE_EN
    chk("tog_done_low", 32'(done), 32'h0);
`endif
    tick();
    chk("tog_q1", 32'(q), 32'hF1);
    chk("tog_busy1", 32'(busy), 32'h1);
    tick();
    chk("tog_q2", 32'(q), 32'hF0);
    chk("tog_busy2", 32'(busy), 32'h1);
    tick();
    chk("tog_q3", 32'(q), 32'hF1);
    chk("tog_busy3", 32'(busy), 32'h0);
`ifdef JK_DONE_PULSE_EN
    chk("tog_done", 32'(done), 32'h1);
    chk("tog_done_id", 32'(done_id), 32'h1);
`endif

    // Contention: both valid; last grant was 1 so grants go 0,1,0,1.
    req0_valid = 1'b1; req0_op = 2'b01; req0_mask = 8'hFF; req0_cnt = 4'd1;
    req1_valid = 1'b1; req1_op = 2'b10; req1_mask = 8'h0F; req1_cnt = 4'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fair_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("fair_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      chk("fair_grant", 32'(grant_id), 32'(i % 2));
      tick();
      chk("fair_q", 32'(q), (i % 2 == 0) ? 32'h00 : 32'h0F);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // cnt=0 behaves as one application; a valid pulse during APPLY is not queued.
    req0_valid = 1'b1; req0_op = 2'b10; req0_mask = 8'h80; req0_cnt = 4'd0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b10; req1_mask = 8'h70; req1_cnt = 4'd1;
    #1;
    chk("apply_ready1", 32'(req1_ready), 32'h0);
    req1_valid = 1'b0;
    tick();
    chk("cnt0_q", 32'(q), 32'h8F);
    chk("cnt0_busy", 32'(busy), 32'h0);
    tick();
    chk("noqueue_busy", 32'(busy), 32'h0);
    chk("noqueue_q", 32'(q), 32'h8F);

    // mask=0 TOGGLE: bank occupied one cycle, q unchanged.
    req1_valid = 1'b1; req1_op = 2'b11; req1_mask = 8'h00; req1_cnt = 4'd1;
    tick();
    req1_valid = 1'b0;
    chk("mask0_busy", 32'(busy), 32'h1);
    tick();
    chk("mask0_q", 32'(q), 32'h8F);
    chk("mask0_busy_end", 32'(busy), 32'h0);

    // TOGGLE all bits cnt=15, reset after the fifth application.
    req0_valid = 1'b1; req0_op = 2'b11; req0_mask = 8'hFF; req0_cnt = 4'd15;
    tick();
    req0_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("long_q", 32'(q), (i % 2 == 1) ? 32'h70 : 32'h8F);
      chk("long_busy", 32'(busy), 32'h1);
    end
    rst = 1'b1;
    #1;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_q", 32'(q), 32'h00);
      chk("post_abort_busy", 32'(busy), 32'h0);
`ifdef JK_DONE_PULSE_EN
      chk("post_abort_done", 32'(done), 32'h0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one WIDTH-bit register bank of JK cells between two requesters.
- Each requester issues commands of the form op + bit mask + repeat count. The block arbitrates round-robin and sequences each command onto the bank's J/K inputs for the requested number of clock edges.
- Sits between software-style command sources and the JK state bank; q is the bank state.

Parameters:
- WIDTH, 8, number of JK cells in the bank.
- CNT_W, 4, width of the repeat-count field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  2  00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE.
- req0_mask  input  WIDTH  bits the op applies to.
- req0_cnt  input  CNT_W  number of applications; 0 is treated as 1.
- req1_valid, req1_ready, req1_op, req1_mask, req1_cnt: same as requester 0, for requester 1.
- q  output  WIDTH  bank state.
- busy  output  1  command in progress.
- grant_id  output  1  requester of the current or last accepted command.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset values: q=0, busy=0, grant_id=0, state IDLE, round-robin pointer set so requester 0 wins first. Reset mid-APPLY aborts the command, with no partial completion afterward.
- Per-bit JK mapping: masked bit gets {j,k} = op. Unmasked bits get 00, so they hold.
- Per-bit JK truth table: 00 hold, 01 q<=0, 10 q<=1, 11 q<=~q.
- FSM states: IDLE, APPLY.
- IDLE arbitration:
  - One valid requester: it is selected.
  - Both valid: the requester not granted last time is selected.
  - req<i>_ready = (state==IDLE) && selected==i. Ready is combinational from valid.
  - Requesters must not make valid depend on ready.
  - Handshake fires when valid && ready. On that edge: latch op/mask/cnt, set grant_id, update the pointer, go to APPLY, set busy=1.
- APPLY:
  - Each rising edge applies the latched op to q and decrements the remaining count.
  - Command accepted at edge N: q changes at edges N+1 .. N+max(cnt,1).
  - After the last application: IDLE, busy=0.
  - One-cycle IDLE bubble between commands; no back-to-back acceptance.
- Fixed rules:
  - HOLD with any cnt occupies the bank for cnt cycles with q unchanged.
  - mask=0 behaves the same as HOLD.
  - Valid deasserted while not ready: no effect, nothing queued.
  - Count arithmetic is CNT_W-bit unsigned; the maximum is 2^CNT_W-1 applications. No wrap, because 0 maps to 1.
- Requester starvation is impossible: after a grant to i, the other requester wins the next contention.

Optional Feature:
- Macro: JK_DONE_PULSE_EN.
- Defined: adds output done (1 bit), high for exactly one cycle in the cycle after the final application edge (first IDLE cycle), plus done_id (1 bit) = grant_id of the finished command. done resets to 0. A reset-aborted command produces no done.
- Undefined: ports absent; all other behaviour identical.

Decomposition:
- Package jk_pkg: op encoding constants (OP_HOLD, OP_CLEAR, OP_SET, OP_TOGGLE), FSM state typedef.
- Sub-module jk_cell: single JK storage bit with clk, rst (async high, clears to 0), j, k, q. The bank is a generate of WIDTH jk_cell instances.
- Arbiter, FSM and counter stay in jk_bank_arbiter.

Test Plan:
- Reset: assert rst mid-cycle -> q=0, busy=0, both ready=0 while rst high; after release, ready only on a valid requester.
- Single command: req0 SET mask=8'hF0 cnt=1 -> q=8'hF0 one edge after accept; busy high 1 cycle; grant_id=0.
- Repeat toggle: from q=8'h00, req1 TOGGLE mask=8'h01 cnt=3 -> q bit0 sequence 1,0,1 on three consecutive edges; final q=8'h01; busy high 3 cycles.
- Contention and fairness: both valid continuously with CLEAR mask=8'hFF cnt=1 (req0) and SET mask=8'h0F cnt=1 (req1) -> grants alternate 0,1,0,1; q alternates 8'h00, 8'h0F.
- Edge cases: cnt=0 treated as 1 application; mask=0 TOGGLE leaves q unchanged but busy=1 for one cycle.
- Mid-APPLY reset: reset asserted during TOGGLE cnt=15 at application 5 -> q=0 immediately, IDLE after release, no further toggles. With JK_DONE_PULSE_EN defined, no done pulse; in the normal case done=1 for one cycle with done_id correct.
